// File: rtl/axi_read_data_router.sv
// AXI R-channel router: steers slave beats to the master named in the upper RID bits.
// Each master has a burst-locked round-robin arbiter feeding a 2-entry skid FIFO.
module axi_read_data_router #(
  parameter int NUM_M     = 2,
  parameter int NUM_S     = 3,
  parameter int ID_BITS   = 4,
  parameter int IDS_BITS  = 8,
  parameter int DATA_BITS = 32
) (
  input  logic                         ACLK,
  input  logic                         ARESETn,
  input  logic [NUM_S*IDS_BITS-1:0]    RID_S,
  input  logic [NUM_S*DATA_BITS-1:0]   RDATA_S,
  input  logic [NUM_S*2-1:0]           RRESP_S,
  input  logic [NUM_S-1:0]             RLAST_S,
  input  logic [NUM_S-1:0]             RVALID_S,
  output logic [NUM_S-1:0]             RREADY_S,
  output logic [NUM_M*ID_BITS-1:0]     RID_M,
  output logic [NUM_M*DATA_BITS-1:0]   RDATA_M,
  output logic [NUM_M*2-1:0]           RRESP_M,
  output logic [NUM_M-1:0]             RLAST_M,
  output logic [NUM_M-1:0]             RVALID_M,
  input  logic [NUM_M-1:0]             RREADY_M,
  output logic [NUM_S-1:0]             ROUTE_ERR
);

  localparam int DW = IDS_BITS - ID_BITS;
  localparam int SW = (NUM_S > 1) ? $clog2(NUM_S) : 1;
  localparam int EW = ID_BITS + DATA_BITS + 3;

  typedef enum logic { IDLE = 1'b0, LOCKED = 1'b1 } lock_e;

  logic [DW-1:0]    dest      [NUM_S];
  logic [NUM_S-1:0] bad_dest;
  logic [NUM_S-1:0] req       [NUM_M];
  logic [NUM_M-1:0] gnt_vld;
  logic [SW-1:0]    gnt_idx   [NUM_M];
  logic [NUM_M-1:0] push;
  logic [NUM_M-1:0] pop;
  logic [EW-1:0]    push_data [NUM_M];

  lock_e            lock_q     [NUM_M];
  lock_e            lock_d     [NUM_M];
  logic [SW-1:0]    lock_idx_q [NUM_M];
  logic [SW-1:0]    lock_idx_d [NUM_M];
  logic [SW-1:0]    rr_ptr_q   [NUM_M];
  logic [SW-1:0]    rr_ptr_d   [NUM_M];
  logic [1:0]       cnt_q      [NUM_M];
  logic [1:0]       cnt_d      [NUM_M];
  logic             wr_ptr_q   [NUM_M];
  logic             wr_ptr_d   [NUM_M];
  logic             rd_ptr_q   [NUM_M];
  logic             rd_ptr_d   [NUM_M];
  logic [EW-1:0]    mem_q      [NUM_M][2];
  logic [EW-1:0]    mem_d      [NUM_M][2];
  logic [NUM_S-1:0] route_err_q;
  logic [NUM_S-1:0] route_err_d;

  // Stage 0: destination decode, arbitration and slave handshake
  always_comb begin
    for (int s = 0; s < NUM_S; s++) begin
      dest[s]     = RID_S[s*IDS_BITS+ID_BITS +: DW];
      bad_dest[s] = (int'(dest[s]) >= NUM_M);
    end
    for (int m = 0; m < NUM_M; m++) begin
      for (int s = 0; s < NUM_S; s++) begin
        req[m][s] = RVALID_S[s] && (int'(dest[s]) == m);
      end
    end
  end

  always_comb begin
    int idx;
    int g;
    idx = 0;
    g   = 0;
    for (int m = 0; m < NUM_M; m++) begin
      gnt_vld[m] = 1'b0;
      gnt_idx[m] = '0;
      if (lock_q[m] == LOCKED) begin
        // Locked: only the burst owner may proceed, even while it idles.
        gnt_idx[m] = lock_idx_q[m];
        gnt_vld[m] = req[m][lock_idx_q[m]];
      end else begin
        for (int i = 0; i < NUM_S; i++) begin
          idx = (int'(rr_ptr_q[m]) + i) % NUM_S;
          if (!gnt_vld[m] && req[m][idx]) begin
            gnt_vld[m] = 1'b1;
            gnt_idx[m] = SW'(idx);
          end
        end
      end
      push[m] = gnt_vld[m] && (cnt_q[m] != 2'd2);
      pop[m]  = (cnt_q[m] != 2'd0) && RREADY_M[m];
      g = int'(gnt_idx[m]);
      push_data[m] = {RID_S[g*IDS_BITS +: ID_BITS], RDATA_S[g*DATA_BITS +: DATA_BITS],
                      RRESP_S[g*2 +: 2], RLAST_S[g]};
    end
  end

  always_comb begin
    RREADY_S = '0;
    for (int s = 0; s < NUM_S; s++) begin
      RREADY_S[s] = bad_dest[s];
      for (int m = 0; m < NUM_M; m++) begin
        if (push[m] && (int'(gnt_idx[m]) == s)) RREADY_S[s] = 1'b1;
      end
    end
    RREADY_S = RREADY_S & {NUM_S{ARESETn}};
  end

  always_comb begin
    for (int m = 0; m < NUM_M; m++) begin
      lock_d[m]     = lock_q[m];
      lock_idx_d[m] = lock_idx_q[m];
      rr_ptr_d[m]   = rr_ptr_q[m];
      cnt_d[m]      = cnt_q[m];
      wr_ptr_d[m]   = wr_ptr_q[m];
      rd_ptr_d[m]   = rd_ptr_q[m];
      mem_d[m][0]   = mem_q[m][0];
      mem_d[m][1]   = mem_q[m][1];
      if (push[m]) begin
        mem_d[m][wr_ptr_q[m]] = push_data[m];
        wr_ptr_d[m]           = ~wr_ptr_q[m];
        if (push_data[m][0]) begin
          lock_d[m]   = IDLE;
          rr_ptr_d[m] = SW'((int'(gnt_idx[m]) + 1) % NUM_S);
        end else begin
          lock_d[m]     = LOCKED;
          lock_idx_d[m] = gnt_idx[m];
        end
      end
      if (pop[m]) rd_ptr_d[m] = ~rd_ptr_q[m];
      case ({push[m], pop[m]})
        2'b10:   cnt_d[m] = cnt_q[m] + 2'd1;
        2'b01:   cnt_d[m] = cnt_q[m] - 2'd1;
        default: cnt_d[m] = cnt_q[m];
      endcase
    end
    route_err_d = RVALID_S & bad_dest;
  end

  // Stage 1: arbiter state and FIFO control registers
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      for (int m = 0; m < NUM_M; m++) begin
        lock_q[m]     <= IDLE;
        lock_idx_q[m] <= '0;
        rr_ptr_q[m]   <= '0;
        cnt_q[m]      <= 2'd0;
        wr_ptr_q[m]   <= 1'b0;
        rd_ptr_q[m]   <= 1'b0;
      end
      route_err_q <= '0;
    end else begin
      for (int m = 0; m < NUM_M; m++) begin
        lock_q[m]     <= lock_d[m];
        lock_idx_q[m] <= lock_idx_d[m];
        rr_ptr_q[m]   <= rr_ptr_d[m];
        cnt_q[m]      <= cnt_d[m];
        wr_ptr_q[m]   <= wr_ptr_d[m];
        rd_ptr_q[m]   <= rd_ptr_d[m];
      end
      route_err_q <= route_err_d;
    end
  end

  always_ff @(posedge ACLK) begin
    for (int m = 0; m < NUM_M; m++) begin
      mem_q[m][0] <= mem_d[m][0];
      mem_q[m][1] <= mem_d[m][1];
    end
  end

  // Stage 2: master outputs from the FIFO head, zeroed while empty
  always_comb begin
    logic [EW-1:0] head;
    head     = '0;
    RID_M    = '0;
    RDATA_M  = '0;
    RRESP_M  = '0;
    RLAST_M  = '0;
    RVALID_M = '0;
    for (int m = 0; m < NUM_M; m++) begin
      head = (cnt_q[m] != 2'd0) ? mem_q[m][rd_ptr_q[m]] : '0;
      RVALID_M[m]                        = (cnt_q[m] != 2'd0);
      RID_M[m*ID_BITS +: ID_BITS]        = head[EW-1 -: ID_BITS];
      RDATA_M[m*DATA_BITS +: DATA_BITS]  = head[DATA_BITS+2 -: DATA_BITS];
      RRESP_M[m*2 +: 2]                  = head[2:1];
      RLAST_M[m]                         = head[0];
    end
  end

  assign ROUTE_ERR = route_err_q;

endmodule

// File: tb/tb_axi_read_data_router.sv
// Scoreboard bench for axi_read_data_router (2 masters, 3 slaves, 8->4 bit IDs).
module tb_axi_read_data_router;

  localparam int NM = 2;
  localparam int NS = 3;

  logic           ACLK;
  logic           ARESETn;
  logic [NS*8-1:0]  RID_S;
  logic [NS*32-1:0] RDATA_S;
  logic [NS*2-1:0]  RRESP_S;
  logic [NS-1:0]    RLAST_S;
  logic [NS-1:0]    RVALID_S;
  logic [NS-1:0]    RREADY_S;
  logic [NM*4-1:0]  RID_M;
  logic [NM*32-1:0] RDATA_M;
  logic [NM*2-1:0]  RRESP_M;
  logic [NM-1:0]    RLAST_M;
  logic [NM-1:0]    RVALID_M;
  logic [NM-1:0]    RREADY_M;
  logic [NS-1:0]    ROUTE_ERR;

  axi_read_data_router #(
    .NUM_M(NM), .NUM_S(NS), .ID_BITS(4), .IDS_BITS(8), .DATA_BITS(32)
  ) dut (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .RID_S(RID_S), .RDATA_S(RDATA_S), .RRESP_S(RRESP_S), .RLAST_S(RLAST_S),
    .RVALID_S(RVALID_S), .RREADY_S(RREADY_S),
    .RID_M(RID_M), .RDATA_M(RDATA_M), .RRESP_M(RRESP_M), .RLAST_M(RLAST_M),
    .RVALID_M(RVALID_M), .RREADY_M(RREADY_M), .ROUTE_ERR(ROUTE_ERR)
  );

  int n_total = 0;
  int n_pass  = 0;
  int cyc     = 0;
  int c0;
  logic [38:0] q0[$];
  logic [38:0] q1[$];
  logic [38:0] mon_act;
  logic [38:0] mon_exp;
  bit          mon_have;

  initial begin
    ACLK = 1'b0;
    forever #5 ACLK = ~ACLK;
  end

  always @(posedge ACLK) cyc <= cyc + 1;

  initial begin
    #300000;
    $display("FAIL watchdog: actual timeout required completion");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: actual %h required %h", name, act, exp);
  endtask

  task automatic exp_push(input int m, input logic [7:0] rid, input logic [31:0] data,
                          input logic [1:0] resp, input logic last);
    logic [38:0] e;
    e = {rid[3:0], data, resp, last};
    if (m == 0) q0.push_back(e);
    else        q1.push_back(e);
  endtask

  task automatic drive(input int s, input logic [7:0] rid, input logic [31:0] data,
                       input logic [1:0] resp, input logic last);
    RID_S[s*8 +: 8]     = rid;
    RDATA_S[s*32 +: 32] = data;
    RRESP_S[s*2 +: 2]   = resp;
    RLAST_S[s]          = last;
    RVALID_S[s]         = 1'b1;
  endtask

  task automatic idle(input int s);
    RVALID_S[s] = 1'b0;
    RLAST_S[s]  = 1'b0;
  endtask

  task automatic wait_acc(input int s);
    int n;
    n = 0;
    do begin
      @(negedge ACLK);
      n++;
    end while (!RREADY_S[s] && n < 60);
    chk($sformatf("handshake_s%0d", s), 64'(RREADY_S[s]), 64'd1);
    @(posedge ACLK);
    #1;
  endtask

  task automatic send(input int s, input logic [7:0] rid, input logic [31:0] data,
                      input logic [1:0] resp, input logic last);
    drive(s, rid, data, resp, last);
    wait_acc(s);
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((q0.size() + q1.size()) != 0 && n < 100) begin
      @(posedge ACLK);
      n++;
    end
    @(posedge ACLK);
    #1;
    chk("drain_queue", 64'(q0.size() + q1.size()), 64'd0);
    chk("drain_rvalid", 64'(RVALID_M), 64'd0);
  endtask

  // Monitor: a beat is transferred at the next rising edge when valid and ready are both high.
  always @(negedge ACLK) begin
    if (ARESETn) begin
      for (int m = 0; m < NM; m++) begin
        if (RVALID_M[m] && RREADY_M[m]) begin
          mon_act  = {RID_M[m*4 +: 4], RDATA_M[m*32 +: 32], RRESP_M[m*2 +: 2], RLAST_M[m]};
          mon_have = (m == 0) ? (q0.size() != 0) : (q1.size() != 0);
          if (!mon_have) begin
            n_total++;
            $display("FAIL unexpected_beat_m%0d: actual %h required no beat", m, mon_act);
          end else begin
            if (m == 0) mon_exp = q0.pop_front();
            else        mon_exp = q1.pop_front();
            chk($sformatf("beat_m%0d", m), 64'(mon_act), 64'(mon_exp));
          end
        end
      end
    end
  end

  initial begin
    ARESETn  = 1'b0;
    RID_S    = '0;
    RDATA_S  = '0;
    RRESP_S  = '0;
    RLAST_S  = '0;
    RVALID_S = '0;
    RREADY_M = 2'b11;

    // Reset state, including a bad-destination beat that must not be acknowledged
    drive(2, 8'h50, 32'h1234_5678, 2'b00, 1'b1);
    #3;
    chk("rst_rvalid_m", 64'(RVALID_M), 64'd0);
    chk("rst_rdata_m", 64'(RDATA_M), 64'd0);
    chk("rst_rid_m", 64'(RID_M), 64'd0);
    chk("rst_route_err", 64'(ROUTE_ERR), 64'd0);
    chk("rst_rready_s", 64'(RREADY_S), 64'd0);
    idle(2);
    repeat (2) @(posedge ACLK);
    @(negedge ACLK);
    ARESETn = 1'b1;
    @(posedge ACLK);
    #1;

    // Single beat S1 -> M1
    exp_push(1, 8'h13, 32'hDEADBEEF, 2'b00, 1'b1);
    send(1, 8'h13, 32'hDEADBEEF, 2'b00, 1'b1);
    idle(1);
    chk("single_vld_m1", 64'(RVALID_M[1]), 64'd1);
    chk("single_idle_m0", 64'(RVALID_M[0]), 64'd0);
    chk("single_rid_m1", 64'(RID_M[7:4]), 64'h3);
    chk("single_rr_ptr_m1", 64'(dut.rr_ptr_q[1]), 64'd2);
    wait_drain();

    // Burst lock: S0 4-beat burst, S2 arrives during beat 2 and must wait
    exp_push(0, 8'h05, 32'hA000_0000, 2'b00, 1'b0);
    exp_push(0, 8'h05, 32'hA000_0001, 2'b01, 1'b0);
    exp_push(0, 8'h05, 32'hA000_0002, 2'b00, 1'b0);
    exp_push(0, 8'h05, 32'hA000_0003, 2'b10, 1'b1);
    exp_push(0, 8'h0A, 32'hB000_0000, 2'b00, 1'b0);
    exp_push(0, 8'h0A, 32'hB000_0001, 2'b11, 1'b1);
    fork
      begin
        send(0, 8'h05, 32'hA000_0000, 2'b00, 1'b0);
        send(0, 8'h05, 32'hA000_0001, 2'b01, 1'b0);
        send(0, 8'h05, 32'hA000_0002, 2'b00, 1'b0);
        send(0, 8'h05, 32'hA000_0003, 2'b10, 1'b1);
        idle(0);
      end
      begin
        @(posedge ACLK);
        #1;
        drive(2, 8'h0A, 32'hB000_0000, 2'b00, 1'b0);
        repeat (3) begin
          @(negedge ACLK);
          chk("lock_stall_s2", 64'(RREADY_S[2]), 64'd0);
        end
        wait_acc(2);
        send(2, 8'h0A, 32'hB000_0001, 2'b11, 1'b1);
        idle(2);
      end
    join
    wait_drain();

    // Round robin among three single-beat requesters to M0
    exp_push(0, 8'h01, 32'hC000_0000, 2'b00, 1'b1);
    exp_push(0, 8'h02, 32'hC000_0001, 2'b00, 1'b1);
    exp_push(0, 8'h03, 32'hC000_0002, 2'b00, 1'b1);
    exp_push(0, 8'h01, 32'hC000_0003, 2'b00, 1'b1);
    c0 = cyc;
    fork
      begin
        send(0, 8'h01, 32'hC000_0000, 2'b00, 1'b1);
        send(0, 8'h01, 32'hC000_0003, 2'b00, 1'b1);
        idle(0);
      end
      begin
        send(1, 8'h02, 32'hC000_0001, 2'b00, 1'b1);
        idle(1);
      end
      begin
        send(2, 8'h03, 32'hC000_0002, 2'b00, 1'b1);
        idle(2);
      end
    join
    chk("rr_cycles", 64'(cyc - c0), 64'd4);
    wait_drain();

    // Backpressure: only two beats fit while M0 is stalled
    RREADY_M[0] = 1'b0;
    exp_push(0, 8'h07, 32'hD000_0000, 2'b00, 1'b0);
    exp_push(0, 8'h07, 32'hD000_0001, 2'b00, 1'b0);
    exp_push(0, 8'h07, 32'hD000_0002, 2'b00, 1'b0);
    exp_push(0, 8'h07, 32'hD000_0003, 2'b00, 1'b1);
    fork
      begin
        send(0, 8'h07, 32'hD000_0000, 2'b00, 1'b0);
        send(0, 8'h07, 32'hD000_0001, 2'b00, 1'b0);
        send(0, 8'h07, 32'hD000_0002, 2'b00, 1'b0);
        send(0, 8'h07, 32'hD000_0003, 2'b00, 1'b1);
        idle(0);
      end
      begin
        repeat (2) @(posedge ACLK);
        #1;
        repeat (3) begin
          @(negedge ACLK);
          chk("bp_stall_s0", 64'(RREADY_S[0]), 64'd0);
          chk("bp_hold_valid", 64'(RVALID_M[0]), 64'd1);
          chk("bp_hold_data", 64'(RDATA_M[31:0]), 64'hD000_0000);
        end
        @(posedge ACLK);
        #1;
        RREADY_M[0] = 1'b1;
      end
    join
    wait_drain();

    // Route error: destination 5 does not exist
    drive(2, 8'h50, 32'h5555_AAAA, 2'b00, 1'b1);
    @(negedge ACLK);
    chk("rerr_ready", 64'(RREADY_S[2]), 64'd1);
    chk("rerr_pre", 64'(ROUTE_ERR), 64'd0);
    @(posedge ACLK);
    #1;
    idle(2);
    chk("rerr_pulse", 64'(ROUTE_ERR), 64'b100);
    chk("rerr_no_valid", 64'(RVALID_M), 64'd0);
    @(posedge ACLK);
    #1;
    chk("rerr_clear", 64'(ROUTE_ERR), 64'd0);
    chk("rerr_no_valid2", 64'(RVALID_M), 64'd0);

    // Reset in the middle of an 8-beat burst with a full M1 FIFO
    RREADY_M[1] = 1'b0;
    send(1, 8'h1C, 32'hE000_0000, 2'b00, 1'b0);
    send(1, 8'h1C, 32'hE000_0001, 2'b00, 1'b0);
    drive(1, 8'h1C, 32'hE000_0002, 2'b00, 1'b0);
    @(negedge ACLK);
    chk("full_stall_s1", 64'(RREADY_S[1]), 64'd0);
    chk("full_valid_m1", 64'(RVALID_M[1]), 64'd1);
    #2;
    ARESETn = 1'b0;
    #1;
    chk("mid_rst_rvalid", 64'(RVALID_M), 64'd0);
    chk("mid_rst_rdata", 64'(RDATA_M), 64'd0);
    chk("mid_rst_rlast", 64'(RLAST_M), 64'd0);
    chk("mid_rst_rready_s", 64'(RREADY_S), 64'd0);
    idle(1);
    RREADY_M[1] = 1'b1;
    @(posedge ACLK);
    @(negedge ACLK);
    ARESETn = 1'b1;
    @(posedge ACLK);
    #1;
    chk("post_rst_rvalid", 64'(RVALID_M), 64'd0);
    exp_push(1, 8'h12, 32'hF000_0000, 2'b00, 1'b0);
    exp_push(1, 8'h12, 32'hF000_0001, 2'b01, 1'b1);
    drive(0, 8'h12, 32'hF000_0000, 2'b00, 1'b0);
    @(negedge ACLK);
    chk("post_rst_idle_grant", 64'(RREADY_S[0]), 64'd1);
    @(posedge ACLK);
    #1;
    send(0, 8'h12, 32'hF000_0001, 2'b01, 1'b1);
    idle(0);
    wait_drain();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
